mul_add_seq_unit: RTL and testbench

Parametrised repeated-addition multiplier with an integrated control path and datapath. It accepts two WIDTH-bit operands on a start pulse and produces a 2*WIDTH-bit product. Signed operation is selectable per operation. It always iterates over the smaller operand magnitude and finishes early when either operand is zero. It is the next-generation successor of the fixed S0–S4 multiply control path and is used wherever a low-area, variable-latency multiplier is needed.

---
 rtl/mul_add_pkg.sv | 16 +
 rtl/mul_add_seq_ctrl.sv | 32 +++
 rtl/mul_add_seq_unit.sv | 75 +++++++
 tb/tb_mul_add_seq_unit.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/mul_add_pkg.sv
// mul_add_pkg: shared state encoding and magnitude helpers for the repeated-addition multiplier
package mul_add_pkg;
  localparam int unsigned MAX_W = 32;
  typedef enum logic [1:0] {IDLE, LOAD, ADD, SIGN} state_e;
  function automatic int unsigned prod_w(input int unsigned w);
    return 2 * w;
  endfunction
  // Returns {sign, magnitude}; the most negative value maps to 2^(w-1), which still fits in w bits.
  function automatic logic [MAX_W:0] mag_sign(input logic [MAX_W-1:0] v, input int unsigned w, input logic sgn);
    logic [MAX_W-1:0] mask;
    logic neg;
    mask = (w >= MAX_W) ? '1 : (32'd1 << w) - 32'd1;
    neg = sgn & v[5'(w - 1)];
    return {neg, neg ? (~v + 32'd1) & mask : v};
  endfunction
endpackage

// File: rtl/mul_add_seq_ctrl.sv
// mul_add_seq_ctrl: IDLE/LOAD/ADD/SIGN sequencer for the repeated-addition multiplier
module mul_add_seq_ctrl
  import mul_add_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  input  logic cnt_zero_i,
  input  logic cnt_last_i,
  output logic load_o,
  output logic add_en_o,
  output logic sign_en_o,
  output logic busy_o
);
  state_e state_q, state_d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start_i ? LOAD : IDLE;
      LOAD:    state_d = cnt_zero_i ? SIGN : ADD;
      ADD:     state_d = cnt_last_i ? SIGN : ADD;
      default: state_d = IDLE;
    endcase
  end
  assign load_o    = state_q == LOAD;
  assign add_en_o  = state_q == ADD;
  assign sign_en_o = state_q == SIGN;
  assign busy_o    = state_q != IDLE;
endmodule

// File: rtl/mul_add_seq_unit.sv
// mul_add_seq_unit: variable-latency signed/unsigned multiplier that adds the larger
// magnitude min(|a|,|b|) times, then applies the result sign.
module mul_add_seq_unit
  import mul_add_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       signed_mode,
  input  logic [WIDTH-1:0]           a,
  input  logic [WIDTH-1:0]           b,
  output logic                       busy,
  output logic                       done,
  output logic [prod_w(WIDTH)-1:0]   product
);
  localparam int unsigned PW = prod_w(WIDTH);
  logic [WIDTH-1:0] a_q, b_q, cnt_q, cnt_d, addend_q, mag_a, mag_b, mn, mx;
  logic [PW-1:0] acc_q, acc_d, product_q, product_d;
  logic sm_q, neg_q, done_q, load, add_en, sign_en, capture, unused_ok;
  logic [MAX_W:0] ma, mb;
  assign ma = mag_sign(MAX_W'(a_q), WIDTH, sm_q);
  assign mb = mag_sign(MAX_W'(b_q), WIDTH, sm_q);
  assign unused_ok = ^{ma, mb};
  assign mag_a = ma[WIDTH-1:0];
  assign mag_b = mb[WIDTH-1:0];
  assign mn = (mag_a < mag_b) ? mag_a : mag_b;
  assign mx = (mag_a < mag_b) ? mag_b : mag_a;
  assign capture = start & ~busy;
  mul_add_seq_ctrl u_ctrl (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start),
    .cnt_zero_i (mn == '0),
    .cnt_last_i (cnt_q == WIDTH'(1)),
    .load_o     (load),
    .add_en_o   (add_en),
    .sign_en_o  (sign_en),
    .busy_o     (busy)
  );
  always_comb begin
    cnt_d     = load ? mn : add_en ? cnt_q - WIDTH'(1) : cnt_q;
    acc_d     = load ? '0 : add_en ? acc_q + PW'(addend_q) : acc_q;
    product_d = sign_en ? (neg_q ? -acc_q : acc_q) : product_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      sm_q      <= 1'b0;
      neg_q     <= 1'b0;
      cnt_q     <= '0;
      addend_q  <= '0;
      acc_q     <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
    end else begin
      if (capture) begin
        a_q  <= a;
        b_q  <= b;
        sm_q <= signed_mode;
      end
      if (load) begin
        addend_q <= mx;
        neg_q    <= ma[MAX_W] ^ mb[MAX_W];
      end
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      product_q <= product_d;
      done_q    <= sign_en;
    end
  assign done    = done_q;
  assign product = product_q;
endmodule

// File: tb/tb_mul_add_seq_unit.sv
// tb_mul_add_seq_unit: directed checks of latency, busy window, product and reset behaviour
module tb_mul_add_seq_unit;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, signed_mode = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic busy, done;
  logic [15:0] product;
  int checks = 0, fails = 0;

  mul_add_seq_unit #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
    .a(a), .b(b), .busy(busy), .done(done), .product(product)
  );

  always #5 clk = ~clk;

  task automatic kick(input logic [7:0] av, input logic [7:0] bv, input logic sm);
    a = av; b = bv; signed_mode = sm; start = 1'b1;
  endtask

  // Edge 0 is the first posedge after kick; lat = edges until done seen, bc = busy samples.
  task automatic wait_done(input bit poke, output int lat, output int bc);
    lat = -1;
    @(posedge clk); #1;
    start = 1'b0;
    bc = busy ? 1 : 0;
    for (int k = 1; k <= 400; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        start = 1'b0;
        return;
      end
      if (busy) bc++;
      if (poke) begin
        a = 8'd9; b = 8'd9; start = 1'b1;
      end
    end
    start = 1'b0;
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (product !== 16'h0) begin fails++; $display("FAIL reset_product: got %h expected 0000", product); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_unsigned;
    int lat, bc;
    kick(8'd7, 8'd5, 1'b0);
    wait_done(1'b0, lat, bc);
    check("u7x5_latency", lat, 7);
    check("u7x5_busy_cycles", bc, 7);
    check("u7x5_product", product, 35);
    @(posedge clk); #1;
    check("u7x5_done_pulse_width", done, 0);
    check("u7x5_product_hold", product, 35);
  endtask

  task automatic test_signed;
    int lat, bc;
    kick(8'hFD, 8'd100, 1'b1);
    wait_done(1'b0, lat, bc);
    check("s_m3x100_latency", lat, 5);
    check("s_m3x100_product", product, 16'hFED4);
  endtask

  task automatic test_zero;
    int lat, bc;
    kick(8'h00, 8'hFF, 1'b0);
    wait_done(1'b0, lat, bc);
    check("u0xFF_latency", lat, 2);
    check("u0xFF_product", product, 0);
    kick(8'hFD, 8'd100, 1'b1);
    wait_done(1'b0, lat, bc);
    kick(8'h00, 8'hFF, 1'b1);
    wait_done(1'b0, lat, bc);
    check("s0xm1_latency", lat, 2);
    check("s0xm1_product", product, 0);
  endtask

  task automatic test_boundary;
    int lat, bc;
    kick(8'h80, 8'h80, 1'b1);
    wait_done(1'b0, lat, bc);
    check("s_m128sq_latency", lat, 130);
    check("s_m128sq_product", product, 16'h4000);
    kick(8'hFF, 8'hFF, 1'b0);
    wait_done(1'b0, lat, bc);
    check("uFFsq_latency", lat, 257);
    check("uFFsq_product", product, 16'hFE01);
    kick(8'h7F, 8'h80, 1'b1);
    wait_done(1'b0, lat, bc);
    check("s127xm128_latency", lat, 129);
    check("s127xm128_product", product, 16'hC080);
  endtask

  task automatic test_busy_ignore;
    int lat, bc;
    kick(8'd7, 8'd5, 1'b0);
    wait_done(1'b1, lat, bc);
    check("ignore_latency", lat, 7);
    check("ignore_product", product, 35);
    repeat (2) @(posedge clk);
    #1;
    check("ignore_no_restart", busy, 0);
  endtask

  task automatic test_back_to_back;
    int lat, bc;
    kick(8'd7, 8'd5, 1'b0);
    wait_done(1'b0, lat, bc);
    check("b2b_first_product", product, 35);
    kick(8'd2, 8'd3, 1'b0);
    wait_done(1'b0, lat, bc);
    check("b2b_second_latency", lat, 4);
    check("b2b_second_product", product, 6);
  endtask

  task automatic test_reset_mid;
    int lat, bc;
    bit saw_done = 1'b0;
    kick(8'd200, 8'd200, 1'b0);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      saw_done |= done;
    end
    check("mid_busy_before_reset", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_reset_busy", busy, 0);
    check("mid_reset_done", done, 0);
    check("mid_reset_product", product, 0);
    repeat (3) begin
      @(posedge clk); #1;
      saw_done |= done;
    end
    check("mid_no_done_pulse", saw_done, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    kick(8'd4, 8'd4, 1'b0);
    wait_done(1'b0, lat, bc);
    check("post_reset_latency", lat, 6);
    check("post_reset_product", product, 16);
  endtask

  initial begin
    test_reset;
    test_unsigned;
    test_signed;
    test_zero;
    test_boundary;
    test_busy_ignore;
    test_back_to_back;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
